mpa_opunit: RTL and testbench
=============================

Name: mpa_opunit

Overview:
- Operational (datapath) unit driven by the microprogram automaton's 4-bit state code (Y0..Y9, Yk).
- Decodes each code into micro-operations on internal registers.
- Returns the condition flags x1/x2 that the automaton branches on.
- Algorithm: load operand A, wait for operand B via handshake, compare, then produce |A-B| with a sign flag and an execution cycle count.

Parameters:
- W, 8, operand/result width.
- CNT_W, 8, cycle counter width (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- y  in  4  state code from the automaton.
- data_in  in  W  operand bus.
- in_valid  in  1  operand B valid.
- in_ready  out  1  operand B accepted this cycle.
- x1  out  1  condition: operand B captured.
- x2  out  1  condition: A >= B.
- result  out  W  |A-B|.
- neg  out  1  1 when A < B.
- out_valid  out  1  result-valid pulse.
- cycles  out  CNT_W  cycles spent from Y1 to the last compute step.
- err  out  1  sticky illegal-code flag.

Behaviour:
- Reset (reset=0, asynchronous): A, B, b_hold, b_flag, result, neg, cycles, err and out_valid all go to 0.
- All register updates occur on the rising clk edge, using the y value present in that cycle.
- Y0 (idle): clear err, b_flag and out_valid; hold result, neg and cycles.
- Y1: A<=0, B<=0, b_flag<=0, out_valid<=0, cycles<=1.
- Y2: A<=data_in (unconditional, no handshake).
- Y3:
  - in_ready = (y==Y3) & ~b_flag, combinational.
  - If in_valid & in_ready: b_hold<=data_in, b_flag<=1.
  - x1 = b_flag (registered), so Y3 lasts at least 2 cycles. The automaton sees x1 one cycle after the acceptance.
  - in_valid arriving while b_flag=1 is ignored (in_ready=0).
- Y4: B<=b_hold, b_flag<=0.
- Y5: no register change. x2 = (A >= B), unsigned, combinational from registers. x2 is meaningful only in Y5 but is driven continuously.
- Y6: result<=B-A (W-bit, no overflow since A<B).
- Y7: neg<=1.
- Y8: result<=A-B, neg<=0.
- Y9: reserved; no operation apart from the cycle count.
- Yk (10): out_valid<=1 for exactly one cycle. It clears on the next edge unless y is still Yk.
- Codes 11..15: err<=1 (sticky until Y0 or reset); no other register changes.
- cycles:
  - Set to 1 in Y1.
  - In Y2..Y9: cycles<=cycles+1, saturating at 2^CNT_W-1.
  - Frozen in Y0, Yk and illegal codes.
- in_ready is 0 in every code other than Y3.
- If reset is asserted mid-operation, all state clears immediately. A later Y1 restarts cleanly.
- A jump directly to Y4 without x1 loads the stale b_hold (0 after reset). This is not an error.

Decomposition:
- Shared package mpa_pkg holds:
  - State-code constants S_Y0..S_Y9 and S_YK, 4 bits wide.
  - The illegal-code range.
- The automaton and mpa_opunit both import these codes so that the encoding stays consistent.
- No sub-module is required. The compare/subtract logic is small enough to stay inline.

Test Plan:
1. Reset: hold reset=0 with in_valid=1 and y=Y3 -> all outputs 0, in_ready=0. After release, y=Y3 and b_flag=0 -> in_ready=1.
2. A=200, B=50, B presented on the first Y3 cycle, sequence Y1,Y2,Y3,Y3,Y4,Y5,Y8,Yk -> x1=1 on the second Y3 cycle, x2=1 in Y5, result=150, neg=0, cycles=7, one-cycle out_valid pulse in the cycle after Yk.
3. A=30, B=100, sequence Y1,Y2,Y3,Y3,Y4,Y5,Y6,Y7,Yk -> x2=0, result=70, neg=1, cycles=8.
4. Delayed B: in_valid held low for 5 Y3 cycles, then high with data_in=9; A=9 -> in_ready high for the whole wait, x1 rises one cycle after acceptance, x2=1 (equal operands), result=0, neg=0.
5. Illegal code: y=13 for one cycle mid-sequence -> err=1 and stays 1 through Y1..Yk; returns to 0 after one Y0 cycle. result and cycles are unaffected by the illegal cycle.
6. Saturation and mid-run reset:
   - Hold y=Y9 for 300 cycles -> cycles=255.
   - Pulse reset low during Y3 after B has been accepted -> x1=0 and cycles=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mpa_pkg.sv
// State-code encoding shared by the microprogram automaton and its operational unit.
`default_nettype none

package mpa_pkg;

  localparam logic [3:0] S_Y0 = 4'd0;
  localparam logic [3:0] S_Y1 = 4'd1;
  localparam logic [3:0] S_Y2 = 4'd2;
  localparam logic [3:0] S_Y3 = 4'd3;
  localparam logic [3:0] S_Y4 = 4'd4;
  localparam logic [3:0] S_Y5 = 4'd5;
  localparam logic [3:0] S_Y6 = 4'd6;
  localparam logic [3:0] S_Y7 = 4'd7;
  localparam logic [3:0] S_Y8 = 4'd8;
  localparam logic [3:0] S_Y9 = 4'd9;
  localparam logic [3:0] S_YK = 4'd10;

  localparam logic [3:0] S_ILL_LO = 4'd11;
  localparam logic [3:0] S_ILL_HI = 4'd15;

  function automatic logic is_illegal(input logic [3:0] code);
    return (code >= S_ILL_LO) && (code <= S_ILL_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mpa_opunit.sv
// Operational unit: decodes automaton state codes into register micro-operations
// computing |A-B|, a sign flag and a saturating cycle count; returns x1/x2 conditions.
`default_nettype none

module mpa_opunit
  import mpa_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       y,
  input  logic [W-1:0]     data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x1,
  output logic             x2,
  output logic [W-1:0]     result,
  output logic             neg,
  output logic             out_valid,
  output logic [CNT_W-1:0] cycles,
  output logic             err
);

  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     b_hold_q, b_hold_d;
  logic             b_flag_q, b_flag_d;
  logic [W-1:0]     result_q, result_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  // Gated by reset so no operand is ever acknowledged while the unit is held in reset.
  assign in_ready = reset && (y == S_Y3) && !b_flag_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    b_hold_d    = b_hold_q;
    b_flag_d    = b_flag_q;
    result_d    = result_q;
    neg_d       = neg_q;
    cycles_d    = cycles_q;
    err_d       = err_q;
    out_valid_d = 1'b0;

    if ((y >= S_Y2) && (y <= S_Y9) && (cycles_q != {CNT_W{1'b1}})) begin
      cycles_d = cycles_q + 1'b1;
    end

    case (y)
      S_Y0: begin
        err_d    = 1'b0;
        b_flag_d = 1'b0;
      end
      S_Y1: begin
        a_d      = '0;
        b_d      = '0;
        b_flag_d = 1'b0;
        cycles_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end
      S_Y2: a_d = data_in;
      S_Y3: begin
        if (accept) begin
          b_hold_d = data_in;
          b_flag_d = 1'b1;
        end
      end
      S_Y4: begin
        b_d      = b_hold_q;
        b_flag_d = 1'b0;
      end
      S_Y6: result_d = b_q - a_q;
      S_Y7: neg_d = 1'b1;
      S_Y8: begin
        result_d = a_q - b_q;
        neg_d    = 1'b0;
      end
      S_YK: out_valid_d = 1'b1;
      default: begin
        if (is_illegal(y)) err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q         <= '0;
      b_q         <= '0;
      b_hold_q    <= '0;
      b_flag_q    <= 1'b0;
      result_q    <= '0;
      neg_q       <= 1'b0;
      cycles_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      b_hold_q    <= b_hold_d;
      b_flag_q    <= b_flag_d;
      result_q    <= result_d;
      neg_q       <= neg_d;
      cycles_q    <= cycles_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign x1        = b_flag_q;
  assign x2        = (a_q >= b_q);
  assign result    = result_q;
  assign neg       = neg_q;
  assign out_valid = out_valid_q;
  assign cycles    = cycles_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mpa_opunit.sv
// Directed self-checking bench for mpa_opunit.
`default_nettype none

module tb_mpa_opunit;
  import mpa_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] y;
  logic [7:0] data_in;
  logic       in_valid;
  logic       in_ready, x1, x2, neg, out_valid, err;
  logic [7:0] result;
  logic [7:0] cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mpa_opunit #(.W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .y(y), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .x1(x1), .x2(x2), .result(result), .neg(neg),
    .out_valid(out_valid), .cycles(cycles), .err(err)
  );

  task automatic step(input logic [3:0] yy, input logic [7:0] d, input logic v);
    y = yy; data_in = d; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; y = S_Y3; in_valid = 1'b1; data_in = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({x1, result, neg, out_valid, cycles, err} !== 20'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0",
                         {x1, result, neg, out_valid, cycles, err});
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    reset = 1'b1; in_valid = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_in_ready: got %b required 1", in_ready);
    end
    step(S_Y0, 8'd0, 1'b0);
  endtask

  task automatic test_a_ge_b();
    step(S_Y1, 8'd0, 1'b0);
    step(S_Y2, 8'd200, 1'b0);
    step(S_Y3, 8'd50, 1'b1);
    n_tests++;
    if (x1 !== 1'b1) begin
      n_fail++; $display("FAIL age_x1: got %b required 1", x1);
    end
    step(S_Y3, 8'd0, 1'b0);
    step(S_Y4, 8'd0, 1'b0);
    y = S_Y5; #1;
    n_tests++;
    if (x2 !== 1'b1) begin
      n_fail++; $display("FAIL age_x2: got %b required 1", x2);
    end
    step(S_Y5, 8'd0, 1'b0);
    step(S_Y8, 8'd0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL age_early_valid: got %b required 0", out_valid);
    end
    step(S_YK, 8'd0, 1'b0);
    n_tests++;
    if ({out_valid, result, neg, cycles} !== {1'b1, 8'd150, 1'b0, 8'd7}) begin
      n_fail++; $display("FAIL age_result: got v=%b r=%0d n=%b c=%0d required v=1 r=150 n=0 c=7",
                         out_valid, result, neg, cycles);
    end
    step(S_Y0, 8'd0, 1'b0);
    n_tests++;
    if ({out_valid, result, cycles} !== {1'b0, 8'd150, 8'd7}) begin
      n_fail++; $display("FAIL age_pulse_end: got v=%b r=%0d c=%0d required v=0 r=150 c=7",
                         out_valid, result, cycles);
    end
  endtask

  task automatic test_a_lt_b();
    step(S_Y1, 8'd0, 1'b0);
    step(S_Y2, 8'd30, 1'b0);
    step(S_Y3, 8'd100, 1'b1);
    step(S_Y3, 8'd0, 1'b0);
    step(S_Y4, 8'd0, 1'b0);
    y = S_Y5; #1;
    n_tests++;
    if (x2 !== 1'b0) begin
      n_fail++; $display("FAIL alt_x2: got %b required 0", x2);
    end
    step(S_Y5, 8'd0, 1'b0);
    step(S_Y6, 8'd0, 1'b0);
    step(S_Y7, 8'd0, 1'b0);
    step(S_YK, 8'd0, 1'b0);
    n_tests++;
    if ({out_valid, result, neg, cycles} !== {1'b1, 8'd70, 1'b1, 8'd8}) begin
      n_fail++; $display("FAIL alt_result: got v=%b r=%0d n=%b c=%0d required v=1 r=70 n=1 c=8",
                         out_valid, result, neg, cycles);
    end
    step(S_Y0, 8'd0, 1'b0);
  endtask

  task automatic test_delayed_b();
    int bad_ready = 0;
    step(S_Y1, 8'd0, 1'b0);
    step(S_Y2, 8'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      y = S_Y3; in_valid = 1'b0; data_in = 8'hFF; #1;
      if (in_ready !== 1'b1 || x1 !== 1'b0) bad_ready++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (bad_ready != 0) begin
      n_fail++; $display("FAIL dly_wait: got %0d bad wait cycles required 0", bad_ready);
    end
    step(S_Y3, 8'd9, 1'b1);
    n_tests++;
    if ({x1, in_ready} !== 2'b10) begin
      n_fail++; $display("FAIL dly_accept: got x1/in_ready=%b%b required 10", x1, in_ready);
    end
    // A second valid while b_flag is set must not overwrite the held operand.
    step(S_Y3, 8'd77, 1'b1);
    step(S_Y4, 8'd0, 1'b0);
    y = S_Y5; #1;
    n_tests++;
    if (x2 !== 1'b1) begin
      n_fail++; $display("FAIL dly_x2: got %b required 1", x2);
    end
    step(S_Y5, 8'd0, 1'b0);
    step(S_Y8, 8'd0, 1'b0);
    step(S_YK, 8'd0, 1'b0);
    n_tests++;
    if ({out_valid, result, neg} !== {1'b1, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL dly_result: got v=%b r=%0d n=%b required v=1 r=0 n=0",
                         out_valid, result, neg);
    end
    step(S_Y0, 8'd0, 1'b0);
  endtask

  task automatic test_illegal();
    step(S_Y1, 8'd0, 1'b0);
    step(S_Y2, 8'd200, 1'b0);
    step(S_Y3, 8'd50, 1'b1);
    step(S_Y3, 8'd0, 1'b0);
    step(4'd13, 8'd0, 1'b0);
    n_tests++;
    if ({err, cycles} !== {1'b1, 8'd4}) begin
      n_fail++; $display("FAIL ill_set: got err=%b c=%0d required err=1 c=4", err, cycles);
    end
    step(S_Y4, 8'd0, 1'b0);
    step(S_Y5, 8'd0, 1'b0);
    step(S_Y8, 8'd0, 1'b0);
    step(S_YK, 8'd0, 1'b0);
    n_tests++;
    if ({err, result, cycles} !== {1'b1, 8'd150, 8'd7}) begin
      n_fail++; $display("FAIL ill_sticky: got err=%b r=%0d c=%0d required err=1 r=150 c=7",
                         err, result, cycles);
    end
    step(S_Y0, 8'd0, 1'b0);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL ill_clear: got %b required 0", err);
    end
  endtask

  task automatic test_saturation_reset();
    step(S_Y1, 8'd0, 1'b0);
    for (int i = 0; i < 300; i++) step(S_Y9, 8'd0, 1'b0);
    n_tests++;
    if (cycles !== 8'd255) begin
      n_fail++; $display("FAIL sat_cycles: got %0d required 255", cycles);
    end
    step(S_Y1, 8'd0, 1'b0);
    step(S_Y2, 8'd5, 1'b0);
    step(S_Y3, 8'd6, 1'b1);
    step(S_Y3, 8'd0, 1'b0);
    n_tests++;
    if ({x1, cycles} !== {1'b1, 8'd4}) begin
      n_fail++; $display("FAIL rst_pre: got x1=%b c=%0d required x1=1 c=4", x1, cycles);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({x1, cycles} !== {1'b0, 8'd0}) begin
      n_fail++; $display("FAIL rst_async: got x1=%b c=%0d required x1=0 c=0", x1, cycles);
    end
    #1 reset = 1'b1;
    step(S_Y1, 8'd0, 1'b0);
    step(S_Y2, 8'd0, 1'b0);
    n_tests++;
    if (cycles !== 8'd2) begin
      n_fail++; $display("FAIL rst_restart: got %0d required 2", cycles);
    end
  endtask

  initial begin
    reset = 1'b0; y = S_Y0; data_in = '0; in_valid = 1'b0;
    test_reset();
    test_a_ge_b();
    test_a_lt_b();
    test_delayed_b();
    test_illegal();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
